// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 8 requesters driving a 3-to-8 decoded select bus.
// Grants are capped at MAX_HOLD cycles, and every release is followed by one dead cycle.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] A,
  output logic       E,
  output logic [7:0] Y,
  output logic       TO
);

  localparam int              CW         = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0]   HOLD_LIMIT = CW'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  logic [2:0]      ptr_q;
  logic [CW-1:0]   cnt_q;

  logic [15:0]     req_dbl;
  logic [7:0]      req_rot;
  logic [2:0]      pick_ofs;
  logic [2:0]      pick_idx;
  logic            any_req;
  logic            cur_req;

  // Rotate the request vector so bit 0 is the current highest-priority index,
  // then take the lowest set bit as the offset from ptr.
  always_comb begin
    req_dbl  = {req, req};
    req_rot  = req_dbl[ptr_q +: 8];
    pick_ofs = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_ofs = 3'(k);
      end
    end
    pick_idx = ptr_q + pick_ofs;
    any_req  = |req;
    cur_req  = req[A];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      A       <= 3'd0;
      E       <= 1'b0;
      TO      <= 1'b0;
    end else begin
      TO <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            A       <= pick_idx;
            E       <= 1'b1;
            cnt_q   <= CW'(1);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // A release wins over a coincident timeout, so TO only fires while req[A] is still high.
          if (!cur_req || (cnt_q == HOLD_LIMIT)) begin
            E       <= 1'b0;
            TO      <= cur_req;
            ptr_q   <= A + 3'd1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          E       <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Y = E ? (8'b1 << A) : 8'b0;

  a_y_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(Y));
  a_e_state   : assert property (@(posedge clk) disable iff (rst) (E == (state_q == GRANT)));

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Randomised and directed bench for rr_decoder_arbiter against a queue-free behavioural model.
module tb_rr_decoder_arbiter;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] A;
  logic       E;
  logic [7:0] Y;
  logic       TO;

  int vectors;
  int miscompares;

  // Behavioural model: who owns the resource, for how long, and who is next in line.
  int         m_owner;
  int         m_last;
  int         m_held;
  int         m_ptr;
  bit         m_to;
  logic [2:0] exp_a;
  logic       exp_e;
  logic [7:0] exp_y;
  logic       exp_to;

  rr_decoder_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .A   (A),
    .E   (E),
    .Y   (Y),
    .TO  (TO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_held  = 0;
    m_ptr   = 0;
    m_to    = 0;
    exp_a   = 3'd0;
    exp_e   = 1'b0;
    exp_y   = 8'd0;
    exp_to  = 1'b0;
  endtask

  task automatic model_outputs();
    exp_a  = 3'(m_last);
    exp_e  = (m_owner >= 0);
    exp_y  = exp_e ? (8'(1) << m_last) : 8'd0;
    exp_to = m_to;
  endtask

  // One clock edge: advance model with the req seen at the edge, then settle 1 time unit.
  task automatic step();
    @(posedge clk);
    m_to = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (m_ptr + k) % 8;
        if (req[i]) begin
          m_owner = i;
          m_last  = i;
          m_held  = 1;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (m_held == MAXH) begin
      m_to    = 1;
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
      m_held++;
    end
    model_outputs();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({A, E, Y, TO} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_state A=%b E=%b Y=%b TO=%b required all zero", A, E, Y, TO);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 8'b0010_0000;
    step();
    vectors++;
    if ({A, E, Y, TO} !== {exp_a, exp_e, exp_y, exp_to} || A !== 3'd5 || E !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pregrant A=%b E=%b Y=%b TO=%b required A=101 E=1 Y=00100000", A, E, Y, TO);
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({A, E, Y, TO} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_async A=%b E=%b Y=%b TO=%b required all zero before clk", A, E, Y, TO);
    end
    model_reset();
    #2;
    rst = 1'b0;
    req = 8'd0;
    step();
    req = 8'b1000_0000;
    step();
    vectors++;
    if ({A, E, Y, TO} !== {exp_a, exp_e, exp_y, exp_to} || A !== 3'd7 || Y !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_first_grant A=%b Y=%b required A=111 Y=10000000", A, Y);
    end
    req = 8'd0;
    step();
    step();
  endtask

  task automatic test_rotation();
    int  grants[$];
    int  to_count;
    logic prev_e;
    prev_e   = E;
    to_count = 0;
    req = 8'hFF;
    for (int n = 0; n < 45; n++) begin
      step();
      vectors++;
      if ({A, E, Y, TO} !== {exp_a, exp_e, exp_y, exp_to}) begin
        miscompares++;
        $display("FAIL rotation step=%0d A=%b E=%b Y=%b TO=%b required A=%b E=%b Y=%b TO=%b",
                 n, A, E, Y, TO, exp_a, exp_e, exp_y, exp_to);
      end
      if (E && !prev_e) grants.push_back(int'(A));
      if (TO) to_count++;
      prev_e = E;
    end
    vectors++;
    if (grants.size() != 9 || to_count != 9) begin
      miscompares++;
      $display("FAIL rotation_count grants=%0d timeouts=%0d required 9 and 9", grants.size(), to_count);
    end else begin
      for (int g = 0; g < 9; g++) begin
        vectors++;
        if (grants[g] != (g % 8)) begin
          miscompares++;
          $display("FAIL rotation_order slot=%0d got=%0d required=%0d", g, grants[g], g % 8);
        end
      end
    end
    req = 8'd0;
    step();
  endtask

  task automatic test_single();
    int ecount;
    ecount = 0;
    req = 8'b0000_0100;
    for (int n = 0; n < 5; n++) begin
      if (n == 3) req = 8'd0;
      step();
      vectors++;
      if ({A, E, Y, TO} !== {exp_a, exp_e, exp_y, exp_to}) begin
        miscompares++;
        $display("FAIL single step=%0d A=%b E=%b Y=%b TO=%b required A=%b E=%b Y=%b TO=%b",
                 n, A, E, Y, TO, exp_a, exp_e, exp_y, exp_to);
      end
      if (E && Y === 8'b0000_0100) ecount++;
    end
    vectors++;
    if (ecount != 3) begin
      miscompares++;
      $display("FAIL single_duration got=%0d cycles required=3", ecount);
    end
    req = 8'hFF;
    step();
    vectors++;
    if (A !== 3'd3 || E !== 1'b1) begin
      miscompares++;
      $display("FAIL single_next_ptr A=%b E=%b required A=011 E=1", A, E);
    end
    req = 8'd0;
    step();
    step();
  endtask

  task automatic test_prio_wrap();
    logic [7:0] seq [9];
    seq = '{8'h20, 8'h20, 8'h00, 8'h21, 8'h21, 8'h20, 8'h20, 8'h00, 8'h00};
    for (int n = 0; n < 9; n++) begin
      req = seq[n];
      step();
      vectors++;
      if ({A, E, Y, TO} !== {exp_a, exp_e, exp_y, exp_to}) begin
        miscompares++;
        $display("FAIL prio_wrap step=%0d A=%b E=%b Y=%b TO=%b required A=%b E=%b Y=%b TO=%b",
                 n, A, E, Y, TO, exp_a, exp_e, exp_y, exp_to);
      end
      if (n == 3) begin
        vectors++;
        if (A !== 3'd0 || E !== 1'b1) begin
          miscompares++;
          $display("FAIL prio_wrap_first A=%b E=%b required A=000 E=1", A, E);
        end
      end
      if (n == 6) begin
        vectors++;
        if (A !== 3'd5 || E !== 1'b1) begin
          miscompares++;
          $display("FAIL prio_wrap_second A=%b E=%b required A=101 E=1", A, E);
        end
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [7:0] seq [7];
    seq = '{8'h04, 8'h06, 8'h06, 8'h02, 8'h02, 8'h00, 8'h00};
    for (int n = 0; n < 7; n++) begin
      req = seq[n];
      step();
      vectors++;
      if ({A, E, Y, TO} !== {exp_a, exp_e, exp_y, exp_to}) begin
        miscompares++;
        $display("FAIL no_preempt step=%0d A=%b E=%b Y=%b TO=%b required A=%b E=%b Y=%b TO=%b",
                 n, A, E, Y, TO, exp_a, exp_e, exp_y, exp_to);
      end
      if (n == 2 || n == 4) begin
        vectors++;
        if (A !== ((n == 2) ? 3'd2 : 3'd1) || E !== 1'b1) begin
          miscompares++;
          $display("FAIL no_preempt_hold step=%0d A=%b E=%b required A=%b E=1",
                   n, A, E, (n == 2) ? 3'd2 : 3'd1);
        end
      end
    end
  endtask

  task automatic test_lone_timeout();
    logic [11:0] epat;
    logic [11:0] tpat;
    logic        abad;
    abad = 1'b0;
    req  = 8'b0000_1000;
    for (int n = 0; n < 12; n++) begin
      step();
      vectors++;
      if ({A, E, Y, TO} !== {exp_a, exp_e, exp_y, exp_to}) begin
        miscompares++;
        $display("FAIL lone_timeout step=%0d A=%b E=%b Y=%b TO=%b required A=%b E=%b Y=%b TO=%b",
                 n, A, E, Y, TO, exp_a, exp_e, exp_y, exp_to);
      end
      epat[11-n] = E;
      tpat[11-n] = TO;
      if (A !== 3'd3) abad = 1'b1;
    end
    vectors++;
    if (epat !== 12'b1111_0111_1011 || tpat !== 12'b0000_1000_0100 || abad) begin
      miscompares++;
      $display("FAIL lone_timeout_pattern E=%b TO=%b A_ok=%0d required E=111101111011 TO=000010000100 A_ok=1",
               epat, tpat, !abad);
    end
    req = 8'd0;
    step();
    step();
  endtask

  task automatic test_random();
    logic [7:0] r;
    r = 8'd0;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      req = r;
      step();
      vectors++;
      if ({A, E, Y, TO} !== {exp_a, exp_e, exp_y, exp_to}) begin
        miscompares++;
        $display("FAIL random step=%0d req=%b A=%b E=%b Y=%b TO=%b required A=%b E=%b Y=%b TO=%b",
                 n, req, A, E, Y, TO, exp_a, exp_e, exp_y, exp_to);
      end
      vectors++;
      if ($countones(Y) > 1) begin
        miscompares++;
        $display("FAIL random_onehot step=%0d Y=%b required at most one bit", n, Y);
      end
    end
    req = 8'd0;
    step();
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req         = 8'd0;
    test_reset();
    test_rotation();
    test_single();
    test_prio_wrap();
    test_no_preempt();
    test_lone_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
